// File: rtl/mac_pkg.sv
// Constants shared with the MAC encapsulation stage and the transmit FIFO
// write-side state encoding.
package mac_pkg;

   localparam int MIN_PAYLOAD_LENGTH = 46;
   localparam int MAX_PAYLOAD_LENGTH = 1500;
   localparam int HEADER_LENGTH      = 14;

   // Longest frame handed to the encapsulation stage; the FCS is appended downstream.
   localparam int MAX_FRAME_BYTES    = HEADER_LENGTH + MAX_PAYLOAD_LENGTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      DISCARD = 2'd2
   } wr_state_e;

endpackage

// File: rtl/mac_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value while rd_en is low.
module mac_sdp_ram #(
   parameter int DEPTH = 4096,
   parameter int WIDTH = 9,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mac_tx_fifo.sv
// Store-and-forward transmit frame buffer: a frame is released to the MAC only
// once its last byte is written and good; bad or oversize frames are rewound.
module mac_tx_fifo #(
   parameter int DEPTH           = 4096,
   parameter int MAX_FRAME_BYTES = mac_pkg::MAX_FRAME_BYTES,
   parameter int ADDR_WIDTH      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tuser,
   input  logic                  s_tlast,
   output logic [7:0]            m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tuser,
   output logic                  m_tlast,
   output logic [ADDR_WIDTH:0]   frame_count,
   output logic                  drop_err,
   output logic                  drop_ovf
);

   import mac_pkg::*;

   localparam int                  LEN_W     = $clog2(MAX_FRAME_BYTES + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [LEN_W-1:0]    LEN_MAX   = LEN_W'(MAX_FRAME_BYTES);
   localparam logic [LEN_W-1:0]    LEN_ONE   = LEN_W'(1);

   wr_state_e           state_q, state_d;
   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] wr_commit_q, wr_commit_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0] frame_count_q, frame_count_d;
   logic [LEN_W-1:0]    frame_len_q, frame_len_d;
   logic                bad_err_q, bad_err_d;
   logic                drop_err_q, drop_err_d;
   logic                drop_ovf_q, drop_ovf_d;
   logic                s_tready_q, s_tready_d;
   logic                m_tvalid_q, m_tvalid_d;

   logic                accept;
   logic                full;
   logic                avail;
   logic                rd_issue;
   logic                consume_last;
   logic                ram_we;
   logic                commit;
   logic [ADDR_WIDTH:0] used;
   logic [8:0]          ram_rdata;

   assign accept       = s_tvalid && s_tready_q;
   assign used         = wr_ptr_q - rd_ptr_q;
   assign full         = (used == DEPTH_CNT);
   assign avail        = (rd_ptr_q != wr_commit_q);
   assign rd_issue     = avail && (!m_tvalid_q || m_tready);
   assign consume_last = m_tvalid_q && m_tready && ram_rdata[8];

   // Write side: bytes land speculatively at wr_ptr; wr_commit only moves on a
   // good tlast, so a dropped frame is undone by pulling wr_ptr back.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      frame_len_d = frame_len_q;
      bad_err_d   = bad_err_q;
      drop_err_d  = 1'b0;
      drop_ovf_d  = 1'b0;
      ram_we      = 1'b0;
      commit      = 1'b0;
      s_tready_d  = 1'b1;

      if (accept) begin
         case (state_q)
            IDLE, WRITE: begin
               if (s_tuser) begin
                  if (s_tlast) begin
                     wr_ptr_d   = wr_commit_q;
                     drop_err_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     bad_err_d = 1'b1;
                     state_d   = DISCARD;
                  end
               end else if (full || (frame_len_q >= LEN_MAX)) begin
                  if (s_tlast) begin
                     wr_ptr_d   = wr_commit_q;
                     drop_ovf_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     bad_err_d = 1'b0;
                     state_d   = DISCARD;
                  end
               end else begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (s_tlast) begin
                     wr_commit_d = wr_ptr_q + PTR_ONE;
                     commit      = 1'b1;
                     state_d     = IDLE;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
            DISCARD: begin
               if (s_tuser) begin
                  bad_err_d = 1'b1;
               end
               if (s_tlast) begin
                  wr_ptr_d   = wr_commit_q;
                  drop_err_d = bad_err_q || s_tuser;
                  drop_ovf_d = !(bad_err_q || s_tuser);
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (s_tlast) begin
            frame_len_d = '0;
         end else if (ram_we) begin
            frame_len_d = frame_len_q + LEN_ONE;
         end
      end
   end

   // Read side: the RAM read register is the output register, so it simply
   // stops loading while the MAC stalls.
   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      m_tvalid_d    = m_tvalid_q;
      frame_count_d = frame_count_q;

      if (rd_issue) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         m_tvalid_d = 1'b1;
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end

      case ({commit, consume_last})
         2'b10:   frame_count_d = frame_count_q + PTR_ONE;
         2'b01:   frame_count_d = frame_count_q - PTR_ONE;
         default: frame_count_d = frame_count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         wr_commit_q   <= '0;
         rd_ptr_q      <= '0;
         frame_count_q <= '0;
         frame_len_q   <= '0;
         bad_err_q     <= 1'b0;
         drop_err_q    <= 1'b0;
         drop_ovf_q    <= 1'b0;
         s_tready_q    <= 1'b0;
         m_tvalid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         wr_commit_q   <= wr_commit_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_count_q <= frame_count_d;
         frame_len_q   <= frame_len_d;
         bad_err_q     <= bad_err_d;
         drop_err_q    <= drop_err_d;
         drop_ovf_q    <= drop_ovf_d;
         s_tready_q    <= s_tready_d;
         m_tvalid_q    <= m_tvalid_d;
      end
   end

   mac_sdp_ram #(
      .DEPTH (DEPTH),
      .WIDTH (9),
      .AW    (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data ({s_tlast, s_tdata}),
      .rd_en   (rd_issue),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (ram_rdata)
   );

   assign s_tready    = s_tready_q;
   assign m_tdata     = ram_rdata[7:0];
   assign m_tlast     = ram_rdata[8];
   assign m_tvalid    = m_tvalid_q;
   assign m_tuser     = 1'b0;
   assign frame_count = frame_count_q;
   assign drop_err    = drop_err_q;
   assign drop_ovf    = drop_ovf_q;

endmodule

// File: tb/tb_mac_tx_fifo.sv
// Directed bench for mac_tx_fifo: a frame-level vector table on a full-size
// instance plus hand sequences for latency, overflow, stalls and reset.
module tb_mac_tx_fifo;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]  a_s_tdata, b_s_tdata;
   logic        a_s_tvalid, a_s_tuser, a_s_tlast, a_m_tready;
   logic        b_s_tvalid, b_s_tuser, b_s_tlast, b_m_tready;
   logic        a_s_tready, a_m_tvalid, a_m_tuser, a_m_tlast, a_drop_err, a_drop_ovf;
   logic        b_s_tready, b_m_tvalid, b_m_tuser, b_m_tlast, b_drop_err, b_drop_ovf;
   logic [7:0]  a_m_tdata, b_m_tdata;
   logic [12:0] a_frame_count;
   logic [7:0]  b_frame_count;

   mac_tx_fifo dut_a (
      .clk(clk), .reset(reset),
      .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
      .s_tuser(a_s_tuser), .s_tlast(a_s_tlast),
      .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
      .m_tuser(a_m_tuser), .m_tlast(a_m_tlast),
      .frame_count(a_frame_count), .drop_err(a_drop_err), .drop_ovf(a_drop_ovf)
   );

   mac_tx_fifo #(.DEPTH(128), .MAX_FRAME_BYTES(128)) dut_b (
      .clk(clk), .reset(reset),
      .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
      .s_tuser(b_s_tuser), .s_tlast(b_s_tlast),
      .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
      .m_tuser(b_m_tuser), .m_tlast(b_m_tlast),
      .frame_count(b_frame_count), .drop_err(b_drop_err), .drop_ovf(b_drop_ovf)
   );

   int errors = 0;
   int checks = 0;

   logic [8:0] rxq_a[$], rxq_b[$], expq_a[$], expq_b[$];
   int         derr_a = 0, dovf_a = 0, derr_b = 0, dovf_b = 0;
   int         hold_viol_a = 0, tuser_a = 0;
   logic       hold_pend_a = 1'b0;
   logic [8:0] hold_val_a = '0;

   // Output monitors sample mid-cycle; a beat seen here is taken at the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         hold_pend_a <= 1'b0;
      end else begin
         if (hold_pend_a && !(a_m_tvalid && ({a_m_tlast, a_m_tdata} == hold_val_a)))
            hold_viol_a <= hold_viol_a + 1;
         hold_pend_a <= a_m_tvalid && !a_m_tready;
         hold_val_a  <= {a_m_tlast, a_m_tdata};
         if (a_m_tvalid && a_m_tready) begin
            rxq_a.push_back({a_m_tlast, a_m_tdata});
            if (a_m_tuser) tuser_a <= tuser_a + 1;
         end
         if (a_drop_err) derr_a <= derr_a + 1;
         if (a_drop_ovf) dovf_a <= dovf_a + 1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (b_m_tvalid && b_m_tready) rxq_b.push_back({b_m_tlast, b_m_tdata});
         if (b_drop_err) derr_b <= derr_b + 1;
         if (b_drop_ovf) dovf_b <= dovf_b + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic send(input bit sel, input int len, input int bad, input int base, input bit pass);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = 8'(base + i);
         if (sel) begin
            b_s_tdata = d; b_s_tvalid = 1'b1; b_s_tuser = (i == bad); b_s_tlast = (i == len - 1);
            if (pass) expq_b.push_back({(i == len - 1), d});
         end else begin
            a_s_tdata = d; a_s_tvalid = 1'b1; a_s_tuser = (i == bad); a_s_tlast = (i == len - 1);
            if (pass) expq_a.push_back({(i == len - 1), d});
         end
         @(posedge clk); #1;
      end
      a_s_tvalid = 1'b0; a_s_tuser = 1'b0; a_s_tlast = 1'b0;
      b_s_tvalid = 1'b0; b_s_tuser = 1'b0; b_s_tlast = 1'b0;
   endtask

   task automatic check_rx(input bit sel, input string name);
      int         cyc;
      int         mism;
      logic [8:0] ac[$], ex[$];
      cyc = 0;
      while (cyc < 4000 && ((sel ? rxq_b.size() : rxq_a.size()) < (sel ? expq_b.size() : expq_a.size()))) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (8) @(posedge clk);
      #1;
      if (sel) begin ac = rxq_b; ex = expq_b; end
      else     begin ac = rxq_a; ex = expq_a; end
      chk({name, " beats"}, ac.size(), ex.size());
      mism = -1;
      for (int i = 0; i < ac.size() && i < ex.size(); i++)
         if (mism < 0 && ac[i] !== ex[i]) mism = i;
      checks++;
      if (mism >= 0) begin
         errors++;
         $display("FAIL %s data: beat %0d got {last,data}=%03h, expected %03h", name, mism, ac[mism], ex[mism]);
      end
      if (sel) begin
         chk({name, " frame_count"}, b_frame_count, 0);
         while (rxq_b.size() > 0) void'(rxq_b.pop_front());
         expq_b.delete();
      end else begin
         chk({name, " frame_count"}, a_frame_count, 0);
         chk({name, " hold_stable"}, hold_viol_a, 0);
         chk({name, " m_tuser"}, tuser_a, 0);
         while (rxq_a.size() > 0) void'(rxq_a.pop_front());
         expq_a.delete();
      end
   endtask

   typedef struct {
      int len;
      int bad;
      bit exp_err;
      bit exp_ovf;
      bit exp_pass;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int e0, o0, gap;

      vecs[0] = '{len: 64,   bad: 9,    exp_err: 1, exp_ovf: 0, exp_pass: 0};
      vecs[1] = '{len: 46,   bad: -1,   exp_err: 0, exp_ovf: 0, exp_pass: 1};
      vecs[2] = '{len: 1515, bad: -1,   exp_err: 0, exp_ovf: 1, exp_pass: 0};
      vecs[3] = '{len: 1514, bad: -1,   exp_err: 0, exp_ovf: 0, exp_pass: 1};
      vecs[4] = '{len: 1,    bad: -1,   exp_err: 0, exp_ovf: 0, exp_pass: 1};
      vecs[5] = '{len: 5,    bad: 4,    exp_err: 1, exp_ovf: 0, exp_pass: 0};
      vecs[6] = '{len: 1600, bad: 1550, exp_err: 1, exp_ovf: 0, exp_pass: 0};
      vecs[7] = '{len: 20,   bad: -1,   exp_err: 0, exp_ovf: 0, exp_pass: 1};

      reset = 1'b1;
      a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tuser = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
      b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tuser = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset s_tready", a_s_tready, 0);
      chk("reset m_tvalid", a_m_tvalid, 0);
      chk("reset frame_count", a_frame_count, 0);
      chk("reset drop pulses", {a_drop_err, a_drop_ovf}, 0);
      chk("reset m_tuser", a_m_tuser, 0);
      chk("reset b m_tvalid", b_m_tvalid, 0);
      reset = 1'b0;
      #1;
      chk("s_tready before first clock", a_s_tready, 0);
      @(posedge clk); #1;
      chk("s_tready after first clock", a_s_tready, 1);
      chk("b s_tready after first clock", b_s_tready, 1);

      // 60-byte frame: release latency and gapless streaming.
      send(1'b0, 60, -1, 1, 1'b1);
      chk("lat m_tvalid at commit edge", a_m_tvalid, 0);
      chk("lat frame_count at commit", a_frame_count, 1);
      @(posedge clk); #1;
      chk("lat m_tvalid one edge later", a_m_tvalid, 1);
      chk("lat first byte", a_m_tdata, 8'h01);
      gap = 0;
      for (int k = 0; k < 60; k++) begin
         if (!a_m_tvalid || a_frame_count != 1) gap++;
         @(posedge clk); #1;
      end
      chk("lat gapless beats", gap, 0);
      chk("lat m_tvalid after frame", a_m_tvalid, 0);
      chk("lat frame_count after frame", a_frame_count, 0);
      check_rx(1'b0, "frame60");

      for (int v = 0; v < 8; v++) begin
         e0 = derr_a;
         o0 = dovf_a;
         send(1'b0, vecs[v].len, vecs[v].bad, v * 17 + 5, vecs[v].exp_pass);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("vec%0d drop_err", v), derr_a - e0, vecs[v].exp_err);
         chk($sformatf("vec%0d drop_ovf", v), dovf_a - o0, vecs[v].exp_ovf);
         check_rx(1'b0, $sformatf("vec%0d", v));
      end

      // Small buffer stalled: second frame runs into full and is dropped.
      send(1'b1, 100, -1, 3, 1'b1);
      send(1'b1, 64, -1, 7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("small drop_ovf", dovf_b, 1);
      chk("small drop_err", derr_b, 0);
      chk("small frame_count", b_frame_count, 1);
      chk("small m_tvalid held", b_m_tvalid, 1);
      b_m_tready = 1'b1;
      check_rx(1'b1, "small");

      // Three frames back to back against a stalling sink.
      fork
         begin
            send(1'b0, 50, -1, 11, 1'b1);
            send(1'b0, 50, -1, 61, 1'b1);
            send(1'b0, 50, -1, 111, 1'b1);
         end
         begin
            for (int k = 0; k < 400; k++) begin
               a_m_tready = (k % 2 == 0);
               @(posedge clk); #1;
            end
         end
      join
      a_m_tready = 1'b1;
      check_rx(1'b0, "toggle");

      // Reset in the middle of an outgoing frame.
      send(1'b0, 60, -1, 8'h40, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      chk("midrst m_tvalid before", a_m_tvalid, 1);
      reset = 1'b1;
      #1;
      chk("midrst m_tvalid async", a_m_tvalid, 0);
      chk("midrst frame_count async", a_frame_count, 0);
      chk("midrst s_tready async", a_s_tready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      while (rxq_a.size() > 0) void'(rxq_a.pop_front());
      chk("midrst s_tready back", a_s_tready, 1);
      send(1'b0, 30, -1, 8'h90, 1'b1);
      check_rx(1'b0, "post-reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
